// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave returns results and in_ready.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Add/subtract unit whose WIDTH-bit carry chain is cut into STAGES registered
// CHUNK-bit segments; the whole pipe advances together or stalls together.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign c0           = bus.sub | bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic             vld_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    logic             vld_d;
    logic [WIDTH-1:0] base_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             c_d;
    logic [WIDTH-1:0] sum_d;
    logic [CHUNK:0]   chunk_sum;

    // Stage 0 is fed by the ports; every later stage by its predecessor's registers.
    if (k == 0) begin : src
      assign vld_d  = bus.in_valid;
      assign base_d = '0;
      assign a_d    = bus.a;
      assign b_d    = b_eff;
      assign c_d    = c0;
    end else begin : src
      assign vld_d  = stg[k-1].vld_q;
      assign base_d = stg[k-1].sum_q;
      assign a_d    = stg[k-1].a_q;
      assign b_d    = stg[k-1].b_q;
      assign c_d    = stg[k-1].carry_q;
    end

    assign chunk_sum = {1'b0, a_d[k*CHUNK +: CHUNK]}
                     + {1'b0, b_d[k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_d};

    always_comb begin
      sum_d = base_d;
      sum_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        sum_q   <= '0;
        a_q     <= '0;
        b_q     <= '0;
        carry_q <= 1'b0;
      end else if (adv) begin
        vld_q   <= vld_d;
        sum_q   <= sum_d;
        a_q     <= a_d;
        b_q     <= b_d;
        carry_q <= chunk_sum[CHUNK];
      end
    end

    if (k == STAGES - 1) begin : last
      logic msb_carry;
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB's own sum bit and operands.
      assign msb_carry = a_d[WIDTH-1] ^ b_d[WIDTH-1] ^ chunk_sum[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= msb_carry ^ chunk_sum[CHUNK];
        end
      end

      assign bus.out_valid = vld_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = carry_q;
      assign bus.ovf       = ovf_q;
    end
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit that splits a WIDTH-bit carry chain into STAGES equal segments, with one register boundary per segment. It replaces single-bit full-adder chains in the 32-bit multiplier datapaths, for example in the final carry-propagate addition of partial products. Operands enter through a valid/ready handshake and results leave through another. Throughput is one operation per clock, latency is STAGES cycles, and the whole pipeline stalls under output backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 4, number of pipeline segments (1..WIDTH); CHUNK = WIDTH/STAGES bits added per stage
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/cin/sub are valid
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1 (for sub, 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- Effective inputs: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) holds a valid bit, the low (k+1)*CHUNK result bits computed so far, the unprocessed upper operand bits (a, b_eff), and the running carry.
- Stage k adds a[k*CHUNK +: CHUNK] + b_eff[same] + carry_k, writes those CHUNK sum bits, and passes carry_{k+1} forward.
- The final stage also captures the carry into bit WIDTH-1 so it can form ovf.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- When adv=1, every stage register loads from its predecessor, and stage 0 loads from the inputs with valid = in_valid. When adv=0, all stage registers hold.
- Bubbles are not collapsed. An invalid slot occupies a stage like a valid one.
- Output handshake: a result transfers when out_valid && out_ready. sum/cout/ovf are stable while out_valid=1 and out_ready=0.
- STAGES=1 degenerates to a single registered adder with 1-cycle latency.
- Width rules: internal chunk adds are CHUNK+1 bits wide. No bits beyond WIDTH are retained, except cout.

## Timing
- Reset (rst_n=0, asynchronous): all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 as soon as reset asserts, because it is combinational from out_valid.
- Data registers are also cleared on reset, so outputs are deterministic.
- Reset mid-operation discards every in-flight operand. No result emerges after rst_n deasserts until new inputs arrive.
- Latency: an operand accepted at edge N, with no stall, gives out_valid=1 with its result after edge N+STAGES-1. It is visible in the cycle following edge N+STAGES-1, i.e. STAGES register stages.
- Throughput: one result per cycle while out_ready=1 and in_valid=1.
- Stall: out_valid=1 with out_ready=0 drives in_ready=0 combinationally in the same cycle, and no operand is accepted.
- out_ready=1 in the same cycle as in_valid=1 with a full pipe: the result drains and the new operand enters on the same edge.
- in_valid=1 while in_ready=0: the operand is not consumed and the source must hold it.

## Test plan
- Reset, then WIDTH=32/STAGES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0. This carry ripples through all stages.
- a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1. Then a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Stream 100 random (a, b, cin, sub) tuples back-to-back with out_ready=1 -> 100 results in order, one per cycle after the initial 4-cycle latency, all matching the reference model.
- Same stream with out_ready toggled randomly -> no loss or duplication, in_ready follows the !out_valid || out_ready rule, and outputs are stable during stalls.
- Assert rst_n=0 for one cycle with 3 operations in flight -> out_valid=0 immediately, and no stale results appear afterwards.
- Parameter sweep over (WIDTH, STAGES) = (8,1), (8,8), (16,2), (64,8) with random vectors -> latency equals STAGES and all results are correct.
